// File: rtl/psram_qspi_xfer.sv
// psram_qspi_xfer: runs one QPI read/write transaction on a quad PSRAM.
// Optional PSRAM_CTRL_QPI_INIT_EN: send SPI 0x35 (enter QPI) after reset.
module psram_qspi_xfer #(
   parameter int         DUMMY   = 6,
   parameter int         CE_HIGH = 4,
   parameter logic [7:0] RD_CMD  = 8'hEB,
   parameter logic [7:0] WR_CMD  = 8'h38
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        start,
   input  logic        rd_wr,
   input  logic [23:0] addr,
   input  logic [1:0]  size,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        done,
   output logic        busy,
   output logic        sck,
   output logic        ce_n,
   output logic [3:0]  dout,
   output logic [3:0]  douten,
   input  logic [3:0]  din
);

`ifdef PSRAM_CTRL_QPI_INIT_EN
   localparam logic INIT_EN = 1'b1;
`else
   localparam logic INIT_EN = 1'b0;
`endif

   localparam logic [5:0] DUM_LAST = 6'(DUMMY - 1);
   localparam logic [5:0] CEH_LAST = 6'(CE_HIGH - 1);

   typedef enum logic [2:0] {
      IDLE, INIT, CMD, ADDR, DUMMY_S, DATA, CEH
   } state_t;

   state_t      state_q, state_d, nxt;
   logic [5:0]  cnt_q, cnt_d, lim;
   logic        ph_q;
   logic [63:0] sr_q;
   logic [31:0] rdata_q;
   logic        rd_q, init_q, pend_q;
   logic [1:0]  size_q;
   logic        accept, load_init, tick, active, drive;
   logic [5:0]  data_last;
   logic [4:0]  pos;

   assign active = (state_q == INIT) || (state_q == CMD) ||
                   (state_q == ADDR) || (state_q == DUMMY_S) ||
                   (state_q == DATA);
   assign drive  = (state_q == CMD) || (state_q == ADDR) ||
                   ((state_q == DATA) && !rd_q);
   assign data_last = (size_q == 2'd0) ? 6'd1 :
                      (size_q == 2'd1) ? 6'd3 : 6'd7;
   // byte k/2 of rdata, high nibble first
   assign pos = {cnt_q[2:1], ~cnt_q[0], 2'b00};

   assign sck    = ph_q;
   assign ce_n   = ~active;
   assign busy   = (state_q != IDLE) | pend_q | start;
   assign rdata  = rdata_q;
   assign douten = (state_q == INIT) ? 4'b0001 :
                   drive ? 4'hF : 4'h0;
   assign dout   = (state_q == INIT) ? {3'b000, sr_q[63]} :
                   drive ? sr_q[63:60] : 4'h0;

   // next state: sck-period count in active states, HCLK count in CEH
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      accept    = 1'b0;
      load_init = 1'b0;
      done      = 1'b0;
      lim       = '0;
      nxt       = IDLE;
      unique case (state_q)
         IDLE:    begin lim = '0;        nxt = IDLE; end
         INIT:    begin lim = 6'd7;      nxt = CEH;  end
         CMD:     begin lim = 6'd1;      nxt = ADDR; end
         ADDR:    begin
            lim = 6'd5;
            nxt = (rd_q && DUMMY > 0) ? DUMMY_S : DATA;
         end
         DUMMY_S: begin lim = DUM_LAST;  nxt = DATA; end
         DATA:    begin lim = data_last; nxt = CEH;  end
         CEH:     begin lim = CEH_LAST;  nxt = IDLE; end
         default: begin lim = '0;        nxt = IDLE; end
      endcase
      tick = (state_q == CEH) | ph_q;
      if (state_q == IDLE) begin
         cnt_d = '0;
         if (pend_q) begin
            state_d   = INIT;
            load_init = 1'b1;
         end else if (start) begin
            state_d = CMD;
            accept  = 1'b1;
         end
      end else if (tick) begin
         if (cnt_q == lim) begin
            state_d = nxt;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + 6'd1;
         end
      end
      done = (state_q == CEH) && (cnt_q == lim) && !init_q;
   end

   // state, counter and sck phase
   always_ff @(posedge HCLK or posedge HRESETn) begin
      if (HRESETn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ph_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ph_q    <= active & ~ph_q;
      end
   end

   // request latch, tx shifter (shifts as sck falls) and rx assembly
   always_ff @(posedge HCLK or posedge HRESETn) begin
      if (HRESETn) begin
         sr_q    <= '0;
         rdata_q <= '0;
         rd_q    <= 1'b0;
         size_q  <= '0;
         init_q  <= 1'b0;
         pend_q  <= INIT_EN;
      end else if (load_init) begin
         sr_q   <= {8'h35, 56'd0};
         init_q <= 1'b1;
         pend_q <= 1'b0;
      end else if (accept) begin
         sr_q    <= {rd_wr ? RD_CMD : WR_CMD, addr,
                     wdata[7:0], wdata[15:8],
                     wdata[23:16], wdata[31:24]};
         rd_q    <= rd_wr;
         size_q  <= size;
         init_q  <= 1'b0;
         rdata_q <= '0;
      end else if (ph_q) begin
         if (state_q == INIT)
            sr_q <= {sr_q[62:0], 1'b0};
         else if (drive)
            sr_q <= {sr_q[59:0], 4'h0};
         if ((state_q == DATA) && rd_q)
            rdata_q[pos +: 4] <= din;
      end
   end

endmodule

// File: tb/tb_psram_qspi_xfer.sv
// tb_psram_qspi_xfer: random read/write traffic against a pin-level
// PSRAM model and a byte-array reference of memory contents.
`timescale 1ns/1ps
module tb_psram_qspi_xfer;
   localparam int DUMMY   = 6;
   localparam int CE_HIGH = 4;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b1;
   logic        start = 1'b0;
   logic        rd_wr = 1'b0;
   logic [23:0] addr = '0;
   logic [1:0]  size = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        done, busy, sck, ce_n;
   logic [3:0]  dout, douten;
   logic [3:0]  din = '0;

   int checks = 0;
   int errors = 0;

   psram_qspi_xfer #(.DUMMY(DUMMY), .CE_HIGH(CE_HIGH)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .rd_wr(rd_wr),
      .addr(addr), .size(size), .wdata(wdata), .rdata(rdata),
      .done(done), .busy(busy), .sck(sck), .ce_n(ce_n),
      .dout(dout), .douten(douten), .din(din)
   );

   always #5 HCLK = ~HCLK;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // device memory (driven by pins) and reference memory (by requests)
   logic [7:0] dev_mem [int];
   logic [7:0] ref_mem [int];
   logic [3:0] nib_q[$];
   logic [3:0] oe_q[$];
   int         ce_falls = 0;
   int         gap = 100;
   logic       ce_prev = 1'b1;
   logic [7:0] m_cmd = '0;
   logic [23:0] m_addr = '0;
   int         m_i, m_j, m_a;
   logic [7:0] m_b;

   // PSRAM pin model: latch dout while sck high, drive din for next edge
   always @(negedge HCLK) begin
      din = 4'($urandom);
      if (HRESETn) begin
         ce_prev = 1'b1;
         gap = 100;
      end else begin
         if (ce_prev && !ce_n) begin
            ce_falls++;
            check("ce_gap", 64'(gap >= CE_HIGH), 64'd1);
            nib_q.delete();
            oe_q.delete();
         end
         if (!ce_n && sck) begin
            m_i = nib_q.size();
            if (m_i == 1) m_cmd = {nib_q[0], dout};
            if (m_i >= 2 && m_i < 8) m_addr = {m_addr[19:0], dout};
            if (m_i >= 8 && m_cmd == 8'h38) begin
               m_j = m_i - 8;
               m_a = int'((m_addr + 24'(m_j / 2)) & 24'hFFFFFF);
               m_b = dev_mem.exists(m_a) ? dev_mem[m_a] : 8'h00;
               if (m_j % 2 == 0) m_b[7:4] = dout;
               else m_b[3:0] = dout;
               dev_mem[m_a] = m_b;
            end
            if (m_i >= 8 + DUMMY && m_cmd == 8'hEB) begin
               m_j = m_i - 8 - DUMMY;
               m_a = int'((m_addr + 24'(m_j / 2)) & 24'hFFFFFF);
               m_b = dev_mem.exists(m_a) ? dev_mem[m_a] : 8'h00;
               din = (m_j % 2 == 0) ? m_b[7:4] : m_b[3:0];
            end
            nib_q.push_back(dout);
            oe_q.push_back(douten);
         end
         gap = ce_n ? gap + 1 : 0;
         ce_prev = ce_n;
      end
   end

   function automatic logic [3:0] exp_nib(input logic r,
      input logic [23:0] a, input logic [31:0] wd, input int i);
      logic [7:0] c, b;
      c = r ? 8'hEB : 8'h38;
      if (i == 0) return c[7:4];
      if (i == 1) return c[3:0];
      if (i < 8) return 4'(a >> (4 * (7 - i)));
      if (r) return 4'h0;
      b = 8'(wd >> (8 * ((i - 8) / 2)));
      return ((i - 8) % 2 == 0) ? b[7:4] : b[3:0];
   endfunction

   task automatic xfer(input logic r, input logic [23:0] a,
                       input logic [1:0] sz, input logic [31:0] wd,
                       input bit noise, output logic [31:0] got);
      int n, s, k, falls0, bad_d, bad_oe, lim_d, ba;
      logic [31:0] exp_rd;
      logic seen;
      n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      s = 8 + 2 * n + (r ? DUMMY : 0);
      k = 0;
      while (busy && k < 200) begin
         @(negedge HCLK);
         k++;
      end
      check("ready", 64'(busy), 64'd0);
      exp_rd = '0;
      for (int b = 0; b < n; b++) begin
         ba = int'((a + 24'(b)) & 24'hFFFFFF);
         if (r) exp_rd[8*b +: 8] = ref_mem.exists(ba) ? ref_mem[ba] : 8'h00;
         else ref_mem[ba] = wd[8*b +: 8];
      end
      rd_wr = r; addr = a; size = sz; wdata = wd; start = 1'b1;
      falls0 = ce_falls;
      #1 check("busy_on_start", 64'(busy), 64'd1);
      k = 0;
      seen = 1'b0;
      while (!seen && k < 400) begin
         @(negedge HCLK);
         k++;
         start = 1'b0;
         if (noise && k == 10) begin
            start = 1'b1;
            rd_wr = ~r;
            addr = 24'($urandom);
            size = 2'($urandom);
            wdata = $urandom;
         end
         if (done) seen = 1'b1;
      end
      start = 1'b0;
      check("done_seen", 64'(seen), 64'd1);
      check("latency", 64'(k), 64'(2 * s + CE_HIGH));
      check("sck_cycles", 64'(nib_q.size()), 64'(s));
      check("one_xfer", 64'(ce_falls - falls0), 64'd1);
      bad_d = 0;
      bad_oe = 0;
      lim_d = r ? 8 + DUMMY : s;
      for (int i = 0; i < nib_q.size(); i++) begin
         if (i < lim_d && nib_q[i] !== exp_nib(r, a, wd, i)) bad_d++;
         if (oe_q[i] !== ((r && i >= 8) ? 4'h0 : 4'hF)) bad_oe++;
      end
      check(r ? "rd_stream" : "wr_stream", 64'(bad_d), 64'd0);
      check("oe_stream", 64'(bad_oe), 64'd0);
      if (r) check("rdata", 64'(rdata), 64'(exp_rd));
      got = rdata;
      @(negedge HCLK);
      check("done_pulse", 64'(done), 64'd0);
      check("busy_fall", 64'(busy), 64'd0);
      if (r) check("rdata_hold", 64'(rdata), 64'(exp_rd));
   endtask

   logic [31:0] rd_val;

   initial begin
      repeat (3) @(negedge HCLK);
      check("rst_ce_n", 64'(ce_n), 64'd1);
      check("rst_sck", 64'(sck), 64'd0);
      check("rst_dout", 64'(dout), 64'd0);
      check("rst_douten", 64'(douten), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_rdata", 64'(rdata), 64'd0);
      HRESETn = 1'b0;
      @(negedge HCLK);
      check("busy_after_rst", 64'(busy), 64'd0);

      xfer(1'b0, 24'd0, 2'd2, 32'hABCD1234, 1'b0, rd_val);
      xfer(1'b1, 24'd0, 2'd2, 32'h0, 1'b0, rd_val);
      check("rd_word", 64'(rd_val), 64'hABCD1234);
      xfer(1'b1, 24'd2, 2'd0, 32'h0, 1'b0, rd_val);
      check("rd_byte", 64'(rd_val), 64'h000000CD);
      xfer(1'b0, 24'd100, 2'd2, 32'h88776655, 1'b0, rd_val);
      xfer(1'b1, 24'd100, 2'd1, 32'h0, 1'b0, rd_val);
      check("rd_half", 64'(rd_val), 64'h00006655);
      xfer(1'b0, 24'h10, 2'd3, 32'h5A5AC3C3, 1'b1, rd_val);
      xfer(1'b1, 24'h10, 2'd2, 32'h0, 1'b1, rd_val);

      // reset in the middle of the address phase
      rd_wr = 1'b0; addr = 24'd40; size = 2'd2; wdata = 32'hDEADBEEF;
      start = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge HCLK);
         start = 1'b0;
      end
      check("pre_abort_ce_n", 64'(ce_n), 64'd0);
      HRESETn = 1'b1;
      #1;
      check("abort_ce_n", 64'(ce_n), 64'd1);
      check("abort_sck", 64'(sck), 64'd0);
      check("abort_douten", 64'(douten), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      repeat (2) @(negedge HCLK);
      HRESETn = 1'b0;
      @(negedge HCLK);
      xfer(1'b1, 24'd0, 2'd2, 32'h0, 1'b0, rd_val);
      check("rd_after_abort", 64'(rd_val), 64'hABCD1234);

      for (int t = 0; t < 40; t++)
         xfer(1'($urandom), 24'($urandom_range(0, 63)), 2'($urandom),
              $urandom, ($urandom_range(0, 4) == 0), rd_val);

      repeat (4) @(negedge HCLK);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
